// File: rtl/adder_arb.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder among N_REQ requesters.
// Optional saturating sum: define ADDER_ARB_SATURATE_EN.
module adder_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_sum,
    output logic                   res_carry,
    output logic [IDW-1:0]         res_id
);

    typedef enum logic {IDLE, RESULT} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_nxt;
    logic             found, grant;
    logic [IDW-1:0]   win;
    logic [WIDTH-1:0] op_a, op_b, sum_out;
    logic [WIDTH:0]   sum_full;

    // Scan from ptr upward, wrapping; first valid requester wins.
    always_comb begin : pick
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign grant     = (state_q == IDLE) && found;
    assign req_ready = (grant && !rst) ? (N_REQ'(1) << win) : '0;
    assign res_valid = (state_q == RESULT);

    assign op_a     = req_a[int'(win)*WIDTH +: WIDTH];
    assign op_b     = req_b[int'(win)*WIDTH +: WIDTH];
    assign sum_full = {1'b0, op_a} + {1'b0, op_b};
    assign ptr_nxt  = (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;

`ifdef ADDER_ARB_SATURATE_EN
    assign sum_out = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
`else
    assign sum_out = sum_full[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)     state_d = RESULT;
            RESULT:  if (res_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Result registers load only on a grant, so they hold through backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                res_sum   <= sum_out;
                res_carry <= sum_full[WIDTH];
                res_id    <= win;
                ptr_q     <= ptr_nxt;
            end
        end
    end

endmodule

// File: doc/adder_arb.md
# adder_arb

Round-robin arbiter and sequencer that shares one registered 8-bit adder among several requesters inside the tile. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, performs the add, and presents the sum, carry and requester ID on a single result port with its own valid/ready handshake. It sits between the input pin decode (ui_in/uio_in groups) and the output mux that drives uo_out.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: operand and sum width.
- IDW, $clog2(N_REQ): width of the requester ID.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_a  in  N_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B; same packing as req_a.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_sum  out  WIDTH  registered sum.
- res_carry  out  1  carry out of the add.
- res_id  out  IDW  index of the requester that produced the result.

## Operation
- FSM states:
  - IDLE: no result is held. res_valid = 0.
  - RESULT: a result is held. res_valid = 1.
- IDLE behaviour:
  - The winner is the first index i with req_valid[i] = 1, scanning from ptr upward modulo N_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle. All other ready bits are 0.
  - If no requester is valid, req_ready = 0 and the FSM stays in IDLE.
- On a grant (req_valid[i] & req_ready[i] at a rising edge):
  - {res_carry, res_sum} <= a_i + b_i, computed at WIDTH+1 bits.
  - res_id <= i.
  - ptr <= (i+1) mod N_REQ.
  - FSM -> RESULT.
- RESULT behaviour:
  - req_ready = 0 (no new grant while a result is held).
  - res_sum, res_carry and res_id stay stable until the handshake.
  - On res_valid & res_ready, FSM -> IDLE.
- Requesters not granted keep req_valid asserted and keep their operands stable until granted. The block does not latch or queue losing requests.
- ptr holds its value whenever no grant occurs.
- A requester that drops req_valid before its grant is simply not serviced. This is not an error.

## Timing
- Reset values (asserted asynchronously):
  - FSM = IDLE, ptr = 0.
  - res_valid = 0, res_sum = 0, res_carry = 0, res_id = 0.
  - req_ready = 0 while rst is high.
- Latency: the grant happens in cycle T, and res_valid = 1 from cycle T+1.
- Throughput: at most one result every 2 cycles (grant cycle, then handshake cycle).
- res_ready may already be high when res_valid rises. The handshake then completes in cycle T+1, and the next grant can occur in T+2.
- Backpressure: res_ready = 0 holds the FSM in RESULT indefinitely. Outputs stay stable.
- Simultaneous requests: resolved strictly by the rotating pointer. No requester waits more than N_REQ grants.
- ptr = N_REQ-1 with a grant to N_REQ-1 wraps ptr to 0.
- Reset asserted mid-operation discards any held result. res_valid drops immediately, and no partial handshake is honoured.
- Sum arithmetic is unsigned. Operands are zero-extended to WIDTH+1 bits.

## Configuration
- Macro ADDER_ARB_SATURATE_EN.
- Defined:
  - When the carry is 1, res_sum is forced to all-ones (8'hFF for WIDTH=8).
  - res_carry still reports the true carry.
- Undefined:
  - res_sum = low WIDTH bits of the sum (wrap-around).
  - No saturation logic is built.

## Test plan
- Reset, then single request: after rst, req_valid = 4'b0001, a0 = 8'h12, b0 = 8'h34, res_ready = 1.
  - req_ready = 4'b0001 in the same cycle.
  - Next cycle: res_valid = 1, res_sum = 8'h46, res_carry = 0, res_id = 0.
- Overflow: a = 8'hF0, b = 8'h20.
  - Without the macro: res_sum = 8'h10, res_carry = 1.
  - With ADDER_ARB_SATURATE_EN: res_sum = 8'hFF, res_carry = 1.
- Round-robin: req_valid = 4'b1111 held constant, res_ready = 1.
  - Grant order is 0, 1, 2, 3, 0, and res_id follows that order.
  - One result every 2 cycles.
- Backpressure: hold res_ready = 0 for 5 cycles with other requests pending.
  - req_ready = 0 throughout.
  - res_sum and res_id stay unchanged.
  - One cycle after res_ready rises, the next requester is granted.
- Wrap and skip: ptr = 3, req_valid = 4'b0101.
  - Requester 0 is granted, then ptr = 1.
  - Requester 2 is granted next.
- Reset mid-result: assert rst while res_valid = 1 and res_ready = 0.
  - res_valid = 0 immediately.
  - After release: ptr = 0 and FSM = IDLE.
